// File: rtl/if_stage.sv
// Instruction fetch stage. Keeps at most one SRAM-like request in flight, feeds the decode slot
// through a one-entry buffer, and handles branch redirects, flushes and misaligned fetch PCs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] EXC_PC   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        adelD,
  input  logic        stallD,
  input  logic        branch_takenD,
  input  logic [31:0] branch_targetD,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_busy
);

  // Vectors must be word aligned or the very first fetch would fault.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end
  if (EXC_PC[1:0] != 2'b00) begin : g_bad_exc_pc
    $error("EXC_PC must be word aligned");
  end

  typedef enum logic {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        d_adel_q, d_adel_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        redir_pending_q, redir_pending_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        discard_q, discard_d;
  // Set once the address-error entry has been handed to D, so it is not re-sent.
  logic        adel_sent_q, adel_sent_d;

  logic        misaligned, accept, resp, resp_keep, d_free, branch;
  logic [31:0] delay_pc;

  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign inst_req   = resetn && (state_q == StIdle) && !buf_valid_q && !flush && !misaligned;
  assign accept     = inst_req && inst_addr_ok;
  assign resp       = (state_q == StWait) && inst_data_ok;
  assign resp_keep  = resp && !discard_q && !flush;
  assign d_free     = !d_valid_q || !stallD;
  assign branch     = branch_takenD && d_valid_q && !stallD;
  assign delay_pc   = d_pc_q + 32'd4;

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'd0;
  assign inst_addr  = fetch_pc_q;
  assign instrD     = d_instr_q;
  assign pcD        = d_pc_q;
  assign validD     = d_valid_q;
  assign adelD      = d_adel_q;
  assign fetch_busy = (state_q == StWait);

  // Next-state: request FSM, D slot / buffer routing, fetch PC and redirect bookkeeping.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    req_pc_d        = req_pc_q;
    d_instr_d       = d_instr_q;
    d_pc_d          = d_pc_q;
    d_valid_d       = d_valid_q;
    d_adel_d        = d_adel_q;
    buf_valid_d     = buf_valid_q;
    buf_instr_d     = buf_instr_q;
    buf_pc_d        = buf_pc_q;
    redir_pending_d = redir_pending_q;
    redir_pc_d      = redir_pc_q;
    discard_d       = discard_q;
    adel_sent_d     = adel_sent_q;

    unique case (state_q)
      StIdle: if (accept) state_d = StWait;
      StWait: if (inst_data_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) req_pc_d = fetch_pc_q;
    if (resp) discard_d = 1'b0;

    // Buffer drains first so instruction order is preserved.
    if (d_free) begin
      d_adel_d = 1'b0;
      if (buf_valid_q) begin
        d_instr_d   = buf_instr_q;
        d_pc_d      = buf_pc_q;
        d_valid_d   = 1'b1;
        buf_valid_d = 1'b0;
      end else if (resp_keep) begin
        d_instr_d = inst_rdata;
        d_pc_d    = req_pc_q;
        d_valid_d = 1'b1;
      end else if ((state_q == StIdle) && misaligned && !adel_sent_q) begin
        d_instr_d   = 32'd0;
        d_pc_d      = fetch_pc_q;
        d_valid_d   = 1'b1;
        d_adel_d    = 1'b1;
        adel_sent_d = 1'b1;
      end else begin
        d_valid_d = 1'b0;
      end
    end
    if (resp_keep && !(d_free && !buf_valid_q)) begin
      buf_valid_d = 1'b1;
      buf_instr_d = inst_rdata;
      buf_pc_d    = req_pc_q;
    end

    if (accept) begin
      if (redir_pending_q) begin
        fetch_pc_d      = redir_pc_q;
        redir_pending_d = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end

    // Delay slot not yet requested: let it go out first, then jump.
    if (branch) begin
      if ((fetch_pc_q == delay_pc) && !accept) begin
        redir_pending_d = 1'b1;
        redir_pc_d      = branch_targetD;
      end else begin
        fetch_pc_d = branch_targetD;
      end
    end

    if (flush) begin
      d_valid_d       = 1'b0;
      d_adel_d        = 1'b0;
      buf_valid_d     = 1'b0;
      redir_pending_d = 1'b0;
      adel_sent_d     = 1'b0;
      fetch_pc_d      = flush_pc;
      // A response still owed by the memory belongs to the old stream.
      discard_d       = (state_q == StWait) && !inst_data_ok;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= StIdle;
      fetch_pc_q      <= RESET_PC;
      req_pc_q        <= 32'd0;
      d_instr_q       <= 32'd0;
      d_pc_q          <= 32'd0;
      d_valid_q       <= 1'b0;
      d_adel_q        <= 1'b0;
      buf_valid_q     <= 1'b0;
      buf_instr_q     <= 32'd0;
      buf_pc_q        <= 32'd0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= 32'd0;
      discard_q       <= 1'b0;
      adel_sent_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      req_pc_q        <= req_pc_d;
      d_instr_q       <= d_instr_d;
      d_pc_q          <= d_pc_d;
      d_valid_q       <= d_valid_d;
      d_adel_q        <= d_adel_d;
      buf_valid_q     <= buf_valid_d;
      buf_instr_q     <= buf_instr_d;
      buf_pc_q        <= buf_pc_d;
      redir_pending_q <= redir_pending_d;
      redir_pc_q      <= redir_pc_d;
      discard_q       <= discard_d;
      adel_sent_q     <= adel_sent_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a one-request memory model answers fetches, a recorder logs accepted
// addresses and instructions leaving D, and each test task compares them to its expectations.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'hBFC00000;
  localparam logic [31:0] K   = 32'hA5A55A5A;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [31:0] instrD, pcD, branch_targetD, flush_pc;
  logic        validD, adelD, stallD, branch_takenD, flush, fetch_busy;

  if_stage #(.RESET_PC(32'hBFC00000), .EXC_PC(32'hBFC00380)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .instrD(instrD), .pcD(pcD), .validD(validD), .adelD(adelD),
    .stallD(stallD), .branch_takenD(branch_takenD), .branch_targetD(branch_targetD),
    .flush(flush), .flush_pc(flush_pc), .fetch_busy(fetch_busy)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          budget   = 0;
  bit          dok_en   = 1'b1;
  bit          pend     = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  logic [31:0] exp_req[$], obs_req[$];
  logic [64:0] exp_d[$], obs_d[$];
  time         obs_t[$];

  function automatic logic [64:0] ent(input logic adel, input logic [31:0] pc,
                                      input logic [31:0] ins);
    return {adel, pc, ins};
  endfunction

  // Memory model + recorder: drive at negedge+2, sample at negedge+8 (edge at +10).
  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      inst_addr_ok = (budget > 0);
      inst_data_ok = dok_en && pend;
      inst_rdata   = pend ? (pend_addr ^ K) : 32'hDEADBEEF;
      #6;
      if (inst_data_ok) pend = 1'b0;
      if (resetn && inst_req && inst_addr_ok) begin
        obs_req.push_back(inst_addr);
        pend      = 1'b1;
        pend_addr = inst_addr;
        budget    = budget - 1;
      end
      if (resetn && validD && !stallD && !flush) begin
        obs_d.push_back({adelD, pcD, instrD});
        obs_t.push_back($time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

  task automatic do_reset();
    resetn = 1'b0; stallD = 1'b0; branch_takenD = 1'b0; branch_targetD = 32'd0;
    flush = 1'b0; flush_pc = 32'd0; budget = 0; dok_en = 1'b1;
    repeat (3) @(negedge clk);
    pend = 1'b0;
    resetn = 1'b1;
    exp_req.delete(); obs_req.delete(); exp_d.delete(); obs_d.delete(); obs_t.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; stallD = 1'b0; branch_takenD = 1'b0; branch_targetD = 32'd0;
    flush = 1'b0; flush_pc = 32'd0; budget = 5; dok_en = 1'b1;
    repeat (3) @(negedge clk);
    #5;
    n_checks++; if (inst_req !== 1'b0) $display("FAIL rst_req: got %b want 0", inst_req);
    else n_pass++;
    n_checks++; if (validD !== 1'b0 || adelD !== 1'b0)
      $display("FAIL rst_valid: got %b%b want 00", validD, adelD); else n_pass++;
    n_checks++; if (pcD !== 32'd0 || instrD !== 32'd0)
      $display("FAIL rst_d: got %h/%h want 0/0", pcD, instrD); else n_pass++;
    n_checks++; if (fetch_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", fetch_busy);
    else n_pass++;
    budget = 0;
    @(negedge clk);
    resetn = 1'b1;
    #5;
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== RPC)
      $display("FAIL rst_first_req: got %b %h want 1 %h", inst_req, inst_addr, RPC); else n_pass++;
    n_checks++; if (inst_wr !== 1'b0 || inst_size !== 2'b10 || inst_wdata !== 32'd0)
      $display("FAIL rst_ties: got %b %b %h want 0 10 0", inst_wr, inst_size, inst_wdata);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] e, o;
    logic [64:0] ed, od;
    do_reset();
    budget = 3;
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(RPC + 32'(4 * i));
      exp_d.push_back(ent(1'b0, RPC + 32'(4 * i), (RPC + 32'(4 * i)) ^ K));
    end
    repeat (12) @(negedge clk);
    n_checks++; if (obs_t.size() >= 3 && (obs_t[1] - obs_t[0] != 40 || obs_t[2] - obs_t[1] != 40))
      $display("FAIL seq_rate: got %0t,%0t want 40,40", obs_t[1] - obs_t[0], obs_t[2] - obs_t[1]);
    else n_pass++;
    n_checks++; if (obs_req.size() != exp_req.size())
      $display("FAIL seq_req_n: got %0d want %0d", obs_req.size(), exp_req.size()); else n_pass++;
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      e = exp_req.pop_front(); o = obs_req.pop_front(); n_checks++;
      if (o !== e) $display("FAIL seq_req: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_d.size() != exp_d.size())
      $display("FAIL seq_d_n: got %0d want %0d", obs_d.size(), exp_d.size()); else n_pass++;
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      ed = exp_d.pop_front(); od = obs_d.pop_front(); n_checks++;
      if (od !== ed) $display("FAIL seq_d: got %h want %h", od, ed); else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] e, o;
    logic [64:0] ed, od;
    do_reset();
    budget = 3;
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(RPC + 32'(4 * i));
      exp_d.push_back(ent(1'b0, RPC + 32'(4 * i), (RPC + 32'(4 * i)) ^ K));
    end
    repeat (2) @(negedge clk);
    stallD = 1'b1;
    repeat (4) @(negedge clk);
    #5;
    n_checks++; if (inst_req !== 1'b0 || fetch_busy !== 1'b0)
      $display("FAIL stall_noreq: got %b %b want 0 0", inst_req, fetch_busy); else n_pass++;
    n_checks++; if (validD !== 1'b1 || pcD !== RPC)
      $display("FAIL stall_hold: got %b %h want 1 %h", validD, pcD, RPC); else n_pass++;
    @(negedge clk);
    stallD = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if (obs_req.size() != exp_req.size())
      $display("FAIL stall_req_n: got %0d want %0d", obs_req.size(), exp_req.size()); else n_pass++;
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      e = exp_req.pop_front(); o = obs_req.pop_front(); n_checks++;
      if (o !== e) $display("FAIL stall_req: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_d.size() != exp_d.size())
      $display("FAIL stall_d_n: got %0d want %0d", obs_d.size(), exp_d.size()); else n_pass++;
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      ed = exp_d.pop_front(); od = obs_d.pop_front(); n_checks++;
      if (od !== ed) $display("FAIL stall_d: got %h want %h", od, ed); else n_pass++;
    end
  endtask

  task automatic test_branch();
    logic [31:0] e, o;
    logic [64:0] ed, od;
    logic [31:0] seq[7];
    seq = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00010,
            32'hBFC00014, 32'hBFC00100};
    do_reset();
    budget = 5;
    foreach (seq[i]) begin
      exp_req.push_back(seq[i]);
      exp_d.push_back(ent(1'b0, seq[i], seq[i] ^ K));
    end
    repeat (10) @(negedge clk);
    n_checks++; if (validD !== 1'b1 || pcD !== 32'hBFC00010)
      $display("FAIL br_pre: got %b %h want 1 bfc00010", validD, pcD); else n_pass++;
    branch_takenD = 1'b1; branch_targetD = 32'hBFC00100;
    @(negedge clk);
    branch_takenD = 1'b0; budget = 2;
    repeat (8) @(negedge clk);
    n_checks++; if (obs_req.size() != exp_req.size())
      $display("FAIL br_req_n: got %0d want %0d", obs_req.size(), exp_req.size()); else n_pass++;
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      e = exp_req.pop_front(); o = obs_req.pop_front(); n_checks++;
      if (o !== e) $display("FAIL br_req: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_d.size() != exp_d.size())
      $display("FAIL br_d_n: got %0d want %0d", obs_d.size(), exp_d.size()); else n_pass++;
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      ed = exp_d.pop_front(); od = obs_d.pop_front(); n_checks++;
      if (od !== ed) $display("FAIL br_d: got %h want %h", od, ed); else n_pass++;
    end
  endtask

  task automatic test_flush_wait();
    logic [31:0] e, o;
    logic [64:0] ed, od;
    do_reset();
    budget = 1; dok_en = 1'b0;
    exp_req.push_back(RPC);
    exp_req.push_back(32'hBFC00380);
    exp_d.push_back(ent(1'b0, 32'hBFC00380, 32'hBFC00380 ^ K));
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'hBFC00380;
    #5;
    n_checks++; if (inst_req !== 1'b0 || fetch_busy !== 1'b1)
      $display("FAIL fl_inwait: got %b %b want 0 1", inst_req, fetch_busy); else n_pass++;
    @(negedge clk);
    flush = 1'b0; dok_en = 1'b1; budget = 1;
    @(negedge clk);
    #5;
    n_checks++; if (validD !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00380)
      $display("FAIL fl_after: got %b %b %h want 0 1 bfc00380", validD, inst_req, inst_addr);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (obs_req.size() != exp_req.size())
      $display("FAIL fl_req_n: got %0d want %0d", obs_req.size(), exp_req.size()); else n_pass++;
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      e = exp_req.pop_front(); o = obs_req.pop_front(); n_checks++;
      if (o !== e) $display("FAIL fl_req: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_d.size() != exp_d.size())
      $display("FAIL fl_d_n: got %0d want %0d", obs_d.size(), exp_d.size()); else n_pass++;
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      ed = exp_d.pop_front(); od = obs_d.pop_front(); n_checks++;
      if (od !== ed) $display("FAIL fl_d: got %h want %h", od, ed); else n_pass++;
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] e, o;
    logic [64:0] ed, od;
    do_reset();
    exp_req.push_back(32'hBFC00380);
    exp_d.push_back(ent(1'b1, 32'hBFC00382, 32'd0));
    exp_d.push_back(ent(1'b0, 32'hBFC00380, 32'hBFC00380 ^ K));
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'hBFC00382;
    @(negedge clk);
    flush = 1'b0; budget = 5;
    #5;
    n_checks++; if (inst_req !== 1'b0) $display("FAIL mis_noreq: got %b want 0", inst_req);
    else n_pass++;
    @(negedge clk);
    #5;
    n_checks++; if ({validD, adelD, pcD, instrD} !== {1'b1, 1'b1, 32'hBFC00382, 32'd0})
      $display("FAIL mis_d: got %b %b %h %h want 1 1 bfc00382 0", validD, adelD, pcD, instrD);
    else n_pass++;
    repeat (2) @(negedge clk);
    #5;
    n_checks++; if (inst_req !== 1'b0 || validD !== 1'b0)
      $display("FAIL mis_wait: got %b %b want 0 0", inst_req, validD); else n_pass++;
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'hBFC00380; budget = 1;
    @(negedge clk);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (obs_req.size() != exp_req.size())
      $display("FAIL mis_req_n: got %0d want %0d", obs_req.size(), exp_req.size()); else n_pass++;
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      e = exp_req.pop_front(); o = obs_req.pop_front(); n_checks++;
      if (o !== e) $display("FAIL mis_req: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_d.size() != exp_d.size())
      $display("FAIL mis_d_n: got %0d want %0d", obs_d.size(), exp_d.size()); else n_pass++;
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      ed = exp_d.pop_front(); od = obs_d.pop_front(); n_checks++;
      if (od !== ed) $display("FAIL mis_dq: got %h want %h", od, ed); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, o;
    logic [64:0] ed, od;
    do_reset();
    exp_req.push_back(RPC);
    exp_d.push_back(ent(1'b0, RPC, RPC ^ K));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #5;
      n_checks++; if (inst_req !== 1'b1 || inst_addr !== RPC)
        $display("FAIL b2b_hold%0d: got %b %h want 1 %h", i, inst_req, inst_addr, RPC);
      else n_pass++;
    end
    @(negedge clk);
    budget = 1;
    repeat (5) @(negedge clk);
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      e = exp_req.pop_front(); o = obs_req.pop_front(); n_checks++;
      if (o !== e) $display("FAIL b2b_req: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_d.size() != exp_d.size())
      $display("FAIL b2b_d_n: got %0d want %0d", obs_d.size(), exp_d.size()); else n_pass++;
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      ed = exp_d.pop_front(); od = obs_d.pop_front(); n_checks++;
      if (od !== ed) $display("FAIL b2b_d: got %h want %h", od, ed); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, o;
    logic [64:0] ed, od;
    do_reset();
    budget = 2;
    exp_req.push_back(RPC);
    exp_req.push_back(RPC + 32'd4);
    exp_req.push_back(RPC);
    exp_d.push_back(ent(1'b0, RPC, RPC ^ K));
    exp_d.push_back(ent(1'b0, RPC, RPC ^ K));
    repeat (3) @(negedge clk);
    resetn = 1'b0; dok_en = 1'b0;
    @(negedge clk);
    #5;
    n_checks++; if (inst_req !== 1'b0 || validD !== 1'b0)
      $display("FAIL rm_inrst: got %b %b want 0 0", inst_req, validD); else n_pass++;
    @(negedge clk);
    resetn = 1'b1; dok_en = 1'b1;
    @(negedge clk);
    #5;
    n_checks++; if (validD !== 1'b0 || fetch_busy !== 1'b0 || inst_addr !== RPC)
      $display("FAIL rm_stale: got %b %b %h want 0 0 %h", validD, fetch_busy, inst_addr, RPC);
    else n_pass++;
    budget = 1;
    repeat (5) @(negedge clk);
    n_checks++; if (obs_req.size() != exp_req.size())
      $display("FAIL rm_req_n: got %0d want %0d", obs_req.size(), exp_req.size()); else n_pass++;
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      e = exp_req.pop_front(); o = obs_req.pop_front(); n_checks++;
      if (o !== e) $display("FAIL rm_req: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_d.size() != exp_d.size())
      $display("FAIL rm_d_n: got %0d want %0d", obs_d.size(), exp_d.size()); else n_pass++;
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      ed = exp_d.pop_front(); od = obs_d.pop_front(); n_checks++;
      if (od !== ed) $display("FAIL rm_d: got %h want %h", od, ed); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_flush_wait();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
